// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the instruction memory from the current PC,
// fills the IF/ID register and keeps a one-entry buffer for fetches landing during a stall.
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] cpc,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        flush,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic        pcEn,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_bufInstr;
    logic [31:0] r_bufPc;

    logic        w_pcEn;
    logic        w_ifidLoad;
    logic        w_ifidBubble;
    logic        w_fromBuf;
    logic        w_bufLoad;
    logic        w_bufClear;
    logic [31:0] w_loadInstr;
    logic [31:0] w_loadPc;

    // Priority is halt > flush > stall > ihit; HALTED is left only through reset.
    always_comb begin
        w_nextState  = r_state;
        w_pcEn       = 1'b0;
        w_ifidLoad   = 1'b0;
        w_ifidBubble = 1'b0;
        w_fromBuf    = 1'b0;
        w_bufLoad    = 1'b0;
        w_bufClear   = 1'b0;
        case (r_state)
            FETCH, HOLD: begin
                if (halt) begin
                    w_nextState  = HALTED;
                    w_ifidBubble = 1'b1;
                    w_bufClear   = 1'b1;
                end else if (flush) begin
                    w_nextState  = FETCH;
                    w_ifidBubble = 1'b1;
                    w_bufClear   = 1'b1;
                    w_pcEn       = 1'b1;
                end else if (r_state == HOLD) begin
                    if (!stall) begin
                        w_nextState = FETCH;
                        w_ifidLoad  = 1'b1;
                        w_fromBuf   = 1'b1;
                        w_pcEn      = 1'b1;
                    end
                end else if (stall) begin
                    if (ihit) begin
                        w_nextState = HOLD;
                        w_bufLoad   = 1'b1;
                    end
                end else if (ihit) begin
                    w_ifidLoad = 1'b1;
                    w_pcEn     = 1'b1;
                end else begin
                    w_ifidBubble = 1'b1;
                end
            end
            HALTED: begin
                w_nextState = HALTED;
            end
            default: begin
                w_nextState = FETCH;
            end
        endcase
    end

    assign w_loadInstr = w_fromBuf ? r_bufInstr : iload;
    assign w_loadPc    = w_fromBuf ? r_bufPc    : cpc;

    assign imemaddr = cpc;
    assign imemREN  = nRST & (r_state == FETCH);
    assign pcEn     = nRST & w_pcEn;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_bufInstr <= NOP_INSTR;
            r_bufPc    <= 32'd0;
        end else if (w_bufClear) begin
            r_bufInstr <= NOP_INSTR;
            r_bufPc    <= 32'd0;
        end else if (w_bufLoad) begin
            r_bufInstr <= iload;
            r_bufPc    <= cpc;
        end
    end

    // A bubble only clears valid/instr; pc and npc keep their last values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= 32'd0;
            ifid_npc   <= 32'd0;
        end else if (w_ifidLoad) begin
            ifid_valid <= 1'b1;
            ifid_instr <= w_loadInstr;
            ifid_pc    <= w_loadPc;
            ifid_npc   <= w_loadPc + 32'd4;
        end else if (w_ifidBubble) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: directed vectors plus hand-written reset sequences.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] cpc;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        flush;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pcEn;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] cpc;
        logic        ihit;
        logic [31:0] iload;
        logic        stall;
        logic        flush;
        logic        halt;
        logic        expRen;
        logic        expPcEn;
        logic        expValid;
        logic [31:0] expInstr;
        logic        chkPc;
        logic [31:0] expPc;
        logic [31:0] expNpc;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(.NOP_INSTR(32'h00000000)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .cpc        (cpc),
        .ihit       (ihit),
        .iload      (iload),
        .stall      (stall),
        .flush      (flush),
        .halt       (halt),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .pcEn       (pcEn),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_npc   (ifid_npc)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] c, input logic h, input logic [31:0] ld,
                                input logic s, input logic f, input logic hl,
                                input logic ren, input logic pe, input logic v,
                                input logic [31:0] ins, input logic cp,
                                input logic [31:0] pc, input logic [31:0] npc);
        vec_t t;
        t.cpc = c; t.ihit = h; t.iload = ld; t.stall = s; t.flush = f; t.halt = hl;
        t.expRen = ren; t.expPcEn = pe; t.expValid = v; t.expInstr = ins;
        t.chkPc = cp; t.expPc = pc; t.expNpc = npc;
        return t;
    endfunction

    // Called 1 time unit after a rising edge: drive, check combinational outputs, then registers.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        cpc = v.cpc; ihit = v.ihit; iload = v.iload;
        stall = v.stall; flush = v.flush; halt = v.halt;
        #2;
        checkOutput({tag, ".imemREN"}, {31'd0, imemREN}, {31'd0, v.expRen});
        checkOutput({tag, ".imemaddr"}, imemaddr, v.cpc);
        checkOutput({tag, ".pcEn"}, {31'd0, pcEn}, {31'd0, v.expPcEn});
        @(posedge CLK);
        #1;
        checkOutput({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, v.expValid});
        checkOutput({tag, ".ifid_instr"}, ifid_instr, v.expInstr);
        if (v.chkPc) begin
            checkOutput({tag, ".ifid_pc"}, ifid_pc, v.expPc);
            checkOutput({tag, ".ifid_npc"}, ifid_npc, v.expNpc);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".imemREN"}, {31'd0, imemREN}, 32'd0);
        checkOutput({tag, ".pcEn"}, {31'd0, pcEn}, 32'd0);
        checkOutput({tag, ".ifid_valid"}, {31'd0, ifid_valid}, 32'd0);
        checkOutput({tag, ".ifid_instr"}, ifid_instr, 32'h0);
        checkOutput({tag, ".ifid_pc"}, ifid_pc, 32'h0);
        checkOutput({tag, ".ifid_npc"}, ifid_npc, 32'h0);
    endtask

    initial begin
        nRST = 1'b0; cpc = 32'h0; ihit = 1'b0; iload = 32'h0;
        stall = 1'b0; flush = 1'b0; halt = 1'b0;

        // cpc ihit iload stall flush halt | ren pcEn valid instr chkPc pc npc
        vecs.push_back(mk(32'h0, 1, 32'h20010005, 0, 0, 0, 1, 1, 1, 32'h20010005, 1, 32'h0, 32'h4));
        vecs.push_back(mk(32'h4, 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h4, 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h4, 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h4, 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h40, 1, 32'h8C220000, 1, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h44, 1, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h44, 1, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h44, 1, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h44, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 32'h8C220000, 1, 32'h40, 32'h44));
        vecs.push_back(mk(32'h44, 1, 32'h11111111, 1, 0, 0, 1, 0, 1, 32'h8C220000, 1, 32'h40, 32'h44));
        vecs.push_back(mk(32'h44, 0, 32'h0, 1, 1, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h100, 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h100, 1, 32'h22222222, 0, 0, 0, 1, 1, 1, 32'h22222222, 1, 32'h100, 32'h104));
        vecs.push_back(mk(32'hFFFFFFFC, 1, 32'h33333333, 0, 0, 0, 1, 1, 1, 32'h33333333, 1, 32'hFFFFFFFC, 32'h0));
        vecs.push_back(mk(32'h200, 1, 32'h44444444, 0, 1, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h300, 1, 32'h55555555, 0, 0, 0, 1, 1, 1, 32'h55555555, 1, 32'h300, 32'h304));
        vecs.push_back(mk(32'h304, 0, 32'h0, 1, 0, 0, 1, 0, 1, 32'h55555555, 1, 32'h300, 32'h304));
        vecs.push_back(mk(32'h304, 1, 32'h66666666, 0, 1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h308, 1, 32'h77777777, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(32'h308, 1, 32'h77777777, 0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0));

        @(posedge CLK);
        #1;
        checkResetState("reset");
        checkOutput("reset.imemaddr", imemaddr, 32'h0);

        nRST = 1'b1;
        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Leave HALTED through reset, then fetch normally.
        nRST = 1'b0;
        #2;
        checkResetState("haltReset");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        applyStimulus(mk(32'h80, 1, 32'h66666666, 0, 0, 0, 1, 1, 1, 32'h66666666, 1, 32'h80, 32'h84), 100);

        // Reset while HOLD owns a buffered word: the word must be gone afterwards.
        applyStimulus(mk(32'h84, 1, 32'h99999999, 1, 0, 0, 1, 0, 1, 32'h66666666, 1, 32'h80, 32'h84), 101);
        nRST = 1'b0;
        #2;
        checkResetState("holdReset");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        applyStimulus(mk(32'h84, 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0), 102);
        applyStimulus(mk(32'h84, 1, 32'hAAAAAAAA, 0, 0, 0, 1, 1, 1, 32'hAAAAAAAA, 1, 32'h84, 32'h88), 103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Drives the instruction-memory read port from the current PC and accepts the returned word. Produces the IF/ID pipeline register (valid, instruction, pc, npc) and generates pcEn back to the PC.
- Contains a one-entry hold buffer, so a fetch that completes while decode is stalled is never lost or re-fetched.

Parameters:
- NOP_INSTR, 32'h00000000, instruction value loaded into IF/ID on reset, flush and bubble.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- cpc  input  32  current PC from the PC stage.
- ihit  input  1  instruction memory returned iload this cycle.
- iload  input  32  instruction data from memory.
- stall  input  1  hazard unit: hold IF/ID.
- flush  input  1  taken branch/jump: squash IF/ID and the hold buffer.
- halt  input  1  halt instruction reached commit.
- imemREN  output  1  instruction read enable.
- imemaddr  output  32  instruction read address.
- pcEn  output  1  advance/load PC this cycle.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  32  fetched instruction.
- ifid_pc  output  32  PC of the fetched instruction.
- ifid_npc  output  32  ifid_pc + 4.

Behaviour:
- Clock and reset: one clock, CLK. nRST is asynchronous active-low.
- Reset values:
  - state = FETCH; ifid_valid = 0; ifid_instr = NOP_INSTR; ifid_pc = 0; ifid_npc = 0; hold buffer cleared.
  - imemREN and pcEn are 0 while nRST = 0.
- States: FETCH, HOLD, HALTED.
- imemaddr = cpc in every state (combinational). imemREN = 1 only in FETCH.
- Priority each cycle: halt > flush > stall > ihit.
- FETCH state:
  - ihit & !stall: IF/ID <= {1, iload, cpc, cpc+4} at the next edge; pcEn = 1 in the ihit cycle (combinational). Latency is one edge from ihit to IF/ID.
  - ihit & stall: hold buffer <= {iload, cpc}; IF/ID unchanged; pcEn = 0; next state HOLD.
  - !ihit & !stall: IF/ID <= bubble (valid 0, NOP_INSTR); pcEn = 0.
  - !ihit & stall: IF/ID unchanged; pcEn = 0.
- HOLD state:
  - imemREN = 0; ihit is ignored.
  - stall = 1: remain in HOLD; pcEn = 0.
  - stall = 0: IF/ID <= {1, buffer instr, buffer pc, buffer pc+4}; pcEn = 1; next state FETCH.
- flush (any non-halted state):
  - IF/ID <= bubble; hold buffer discarded; next state FETCH.
  - pcEn = 1 so the PC loads the redirect target selected by control.
  - An ihit in the same cycle is dropped.
- halt:
  - Next state HALTED from any state; IF/ID <= bubble.
  - In HALTED, imemREN = 0 and pcEn = 0. Exit only via nRST.
  - halt together with flush: halt wins, pcEn = 0.
- Arithmetic: npc = pc + 4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- Reset asserted mid-HOLD: the buffered instruction is lost; fetch restarts at cpc.

Test Plan:
- Reset release with cpc=0x0, ihit=1, iload=0x20010005 -> imemREN=1, imemaddr=0x0, pcEn=1 in that cycle; next edge ifid_valid=1, ifid_instr=0x20010005, ifid_pc=0x0, ifid_npc=0x4.
- ihit=1 with stall=1 at cpc=0x40, iload=0x8C220000, stall held 3 cycles -> pcEn=0 and imemREN=0 for those cycles, IF/ID unchanged. Cycle stall drops -> pcEn=1; next edge IF/ID = {1, 0x8C220000, 0x40, 0x44}.
- flush during HOLD with stall=1 -> buffer discarded, pcEn=1, next edge ifid_valid=0 and ifid_instr=0x0, state FETCH with imemREN=1.
- ihit=0 for 4 cycles, no stall -> ifid_valid=0 each edge, pcEn=0 throughout.
- halt=1 together with flush=1 -> pcEn=0; afterwards imemREN=0 permanently, ihit ignored; nRST pulse -> FETCH resumes.
- cpc=0xFFFFFFFC with ihit -> ifid_npc=0x00000000.
